mmm_exp_sequencer: RTL and testbench

- Upstream control stage for mmm_unit. Runs RSA modular exponentiation (left-to-right square-and-multiply) in the Montgomery domain.
- Drives every mmm_unit control strobe and the operand-select codes for the A/B input muxes (muxes live in the datapath).
- Drives the write strobes for the mbar and acc operand registers.
- Scans a WIDTH-bit exponent MSB-first and signals done when the final from-Montgomery conversion is written.

---
 rtl/mmm_exp_sequencer.sv | 146 ++++++++++++++
 tb/tb_mmm_exp_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mmm_exp_sequencer.sv
// mmm_exp_sequencer: left-to-right square-and-multiply control sequencer for mmm_unit.
// Outputs are registered from the next state so every strobe lines up with the state it belongs to.
module mmm_exp_sequencer #(
  parameter int WIDTH      = 8,
  parameter int MMM_CYCLES = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] exp,
  output logic             mmm_en,
  output logic             mmm_rst,
  output logic             mmm_ld_a,
  output logic             mmm_ld_r,
  output logic             mmm_lock,
  output logic [1:0]       a_sel,
  output logic [1:0]       b_sel,
  output logic             wr_mbar,
  output logic             wr_acc,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(MMM_CYCLES + 1);
  typedef enum logic [2:0] {T_IDLE, T_MSG, T_ONE, T_SQ, T_MUL, T_FM, T_DONE} top_t;
  typedef enum logic [2:0] {S_CLR, S_LOAD, S_RUN, S_CAP, S_WR} sub_t;
  top_t top, nt;
  sub_t sub, ns;
  logic [CW-1:0] rcnt, nr;
  logic [BW-1:0] bcnt, nb;
  logic [WIDTH-1:0] e, ne;
  logic last, op;
  logic n_en, n_rst, n_ld_a, n_ld_r, n_lock, n_wm, n_wa, n_busy, n_done;
  logic [1:0] n_a, n_b;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      top      <= T_IDLE;
      sub      <= S_CLR;
      rcnt     <= '0;
      bcnt     <= '0;
      e        <= '0;
      mmm_en   <= 1'b0;
      mmm_rst  <= 1'b1;
      mmm_ld_a <= 1'b0;
      mmm_ld_r <= 1'b0;
      mmm_lock <= 1'b1;
      a_sel    <= 2'd0;
      b_sel    <= 2'd0;
      wr_mbar  <= 1'b0;
      wr_acc   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      top  <= nt;
      sub  <= ns;
      rcnt <= nr;
      bcnt <= nb;
      e    <= ne;
      if (en) begin
        mmm_en   <= n_en;
        mmm_rst  <= n_rst;
        mmm_ld_a <= n_ld_a;
        mmm_ld_r <= n_ld_r;
        mmm_lock <= n_lock;
        a_sel    <= n_a;
        b_sel    <= n_b;
        wr_mbar  <= n_wm;
        wr_acc   <= n_wa;
        busy     <= n_busy;
        done     <= n_done;
      end else begin
        mmm_en <= 1'b0;
      end
    end
  end
  assign last = bcnt == BW'(WIDTH - 1);
  always_comb begin
    nt = top;
    ns = sub;
    nr = rcnt;
    nb = bcnt;
    ne = e;
    if (en) begin
      case (top)
        T_IDLE: if (start) begin
          nt = T_MSG;
          ns = S_CLR;
          nr = '0;
          nb = '0;
          ne = exp;
        end
        T_DONE: nt = T_IDLE;
        T_MSG, T_ONE, T_SQ, T_MUL, T_FM: case (sub)
          S_CLR:  ns = S_LOAD;
          S_LOAD: begin
            ns = S_RUN;
            nr = '0;
          end
          S_RUN: begin
            ns = rcnt == CW'(MMM_CYCLES - 1) ? S_CAP : S_RUN;
            nr = rcnt + 1'b1;
          end
          S_CAP:  ns = S_WR;
          S_WR: begin
            ns = S_CLR;
            case (top)
              T_MSG:   nt = T_ONE;
              T_ONE:   nt = T_SQ;
              T_SQ:    nt = e[WIDTH-1] ? T_MUL : (last ? T_FM : T_SQ);
              T_MUL:   nt = last ? T_FM : T_SQ;
              default: nt = T_DONE;
            endcase
            // a bit is consumed after its SQUARE (bit 0) or its MULT (bit 1)
            if ((top == T_SQ && !e[WIDTH-1]) || top == T_MUL) begin
              ne = e << 1;
              nb = bcnt + 1'b1;
            end
          end
          default: begin
            nt = T_IDLE;
            ns = S_CLR;
          end
        endcase
        default: begin
          nt = T_IDLE;
          ns = S_CLR;
        end
      endcase
    end
  end
  always_comb begin
    op     = nt inside {T_MSG, T_ONE, T_SQ, T_MUL, T_FM};
    n_busy = op;
    n_done = nt == T_DONE;
    n_en   = op && ns != S_WR;
    n_rst  = !(op && ns == S_CLR);
    n_ld_a = op && ns == S_LOAD;
    n_ld_r = op && ns == S_CAP;
    n_lock = !op || ns == S_WR;
    n_wm   = op && ns == S_WR && nt == T_MSG;
    n_wa   = op && ns == S_WR && nt != T_MSG;
    n_a    = nt == T_ONE ? 2'd3 : nt == T_MUL ? 2'd2 : (nt == T_SQ || nt == T_FM) ? 2'd1 : 2'd0;
    n_b    = (nt == T_SQ || nt == T_MUL) ? 2'd1 : nt == T_FM ? 2'd3 : 2'd0;
  end
endmodule

// File: tb/tb_mmm_exp_sequencer.sv
// tb_mmm_exp_sequencer: directed vectors for the exponentiation sequencer with a mod-13 Montgomery model.
module tb_mmm_exp_sequencer;
  localparam int W = 4, MC = 5, OPL = MC + 4;
  localparam int MSG = 7, R2 = 9;
  logic clk = 0, rstb = 1, en = 1, start = 0;
  logic [W-1:0] exp = '0;
  logic mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock, wr_mbar, wr_acc, busy, done;
  logic [1:0] a_sel, b_sel;
  int checks = 0, errors = 0;
  int busy_cnt, done_cnt, wm_cnt, wa_cnt, en_cnt, mul_cyc, proto;
  int ops_q[$];
  int acc_m = 0, mbar_m = 0, r_m = 0;
  logic [3:0] sel_q;
  logic [11:0] snap;
  logic busy_p = 0, en_s = 1;
  typedef struct {
    logic [W-1:0] e;
    int stall, restart, ops, busy_n, mbar_n, acc_n, muls, res;
  } vec_t;
  vec_t vecs[7];

  mmm_exp_sequencer #(.WIDTH(W), .MMM_CYCLES(MC)) dut (
    .clk(clk), .rstb(rstb), .en(en), .start(start), .exp(exp),
    .mmm_en(mmm_en), .mmm_rst(mmm_rst), .mmm_ld_a(mmm_ld_a), .mmm_ld_r(mmm_ld_r),
    .mmm_lock(mmm_lock), .a_sel(a_sel), .b_sel(b_sel), .wr_mbar(wr_mbar),
    .wr_acc(wr_acc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) en_s <= en;

  function automatic int mont(input int a, input int b);
    return (a * b * 9) % 13;
  endfunction

  function automatic int op_code(input logic [1:0] a, input logic [1:0] b);
    return {a, b} == 4'b0000 ? 0 : {a, b} == 4'b1100 ? 1 : {a, b} == 4'b0101 ? 2 :
           {a, b} == 4'b1001 ? 3 : {a, b} == 4'b0111 ? 4 : 9;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : mon
    int a, b;
    a = a_sel == 0 ? MSG : a_sel == 1 ? acc_m : a_sel == 2 ? mbar_m : 1;
    b = b_sel == 0 ? R2 : b_sel == 1 ? acc_m : b_sel == 2 ? mbar_m : 1;
    if (mmm_en && mmm_ld_r) r_m = mont(a, b);
    if (wr_mbar) mbar_m = r_m;
    if (wr_acc) acc_m = r_m;
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    wm_cnt += int'(wr_mbar);
    wa_cnt += int'(wr_acc);
    en_cnt += int'(mmm_en);
    mul_cyc += int'(busy && a_sel == 2 && b_sel == 1);
    if (mmm_en && !mmm_rst) begin
      ops_q.push_back(op_code(a_sel, b_sel));
      sel_q = {a_sel, b_sel};
    end else if (busy && {a_sel, b_sel} != sel_q) proto++;
    if (busy && mmm_lock != (wr_acc | wr_mbar)) proto++;
    if (!busy && !mmm_lock) proto++;
    if (done && (busy || !busy_p)) proto++;
    if (busy && !en_s) begin
      checks++;
      if (mmm_en !== 1'b0 || {mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock, a_sel, b_sel, wr_mbar, wr_acc, busy, done} !== snap) begin
        errors++;
        $display("FAIL stall_freeze: got en=%b outs=%b expected en=0 outs=%b", mmm_en,
                 {mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock, a_sel, b_sel, wr_mbar, wr_acc, busy, done}, snap);
      end
    end else snap = {mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock, a_sel, b_sel, wr_mbar, wr_acc, busy, done};
    busy_p = busy;
  end

  function automatic int outs();
    return int'({mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock, a_sel, b_sel, wr_mbar, wr_acc, busy, done});
  endfunction

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; wm_cnt = 0; wa_cnt = 0; en_cnt = 0; mul_cyc = 0; proto = 0;
    ops_q.delete();
  endtask

  task automatic run(input vec_t v, input int idx);
    int exp_q[$];
    int bad;
    string tag;
    tag = $sformatf("v%0d", idx);
    clear_mon();
    @(posedge clk); #1;
    exp = v.e;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      en = !(v.stall >= 0 && k >= v.stall && k < v.stall + 4);
      start = k == v.restart;
      if (k == v.restart) exp = v.e ^ 4'hF;
      @(posedge clk); #1;
    end
    en = 1;
    start = 0;
    repeat (120) @(posedge clk);
    exp_q = '{0, 1};
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back(2);
      if (v.e[i]) exp_q.push_back(3);
    end
    exp_q.push_back(4);
    bad = ops_q.size() == exp_q.size() ? -1 : ops_q.size();
    for (int i = 0; i < exp_q.size() && i < ops_q.size(); i++)
      if (bad < 0 && ops_q[i] != exp_q[i]) bad = i;
    chk({tag, "_op_seq_bad_idx"}, bad, -1);
    chk({tag, "_ops"}, ops_q.size(), v.ops);
    chk({tag, "_busy_cycles"}, busy_cnt, v.busy_n);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_wr_mbar"}, wm_cnt, v.mbar_n);
    chk({tag, "_wr_acc"}, wa_cnt, v.acc_n);
    chk({tag, "_mul_cycles"}, mul_cyc, v.muls * OPL);
    chk({tag, "_mmm_en_cycles"}, en_cnt, v.ops * (OPL - 1));
    chk({tag, "_protocol_errs"}, proto, 0);
    chk({tag, "_result"}, acc_m, v.res);
  endtask

  initial begin
    vecs[0] = '{4'b1011, -1, -1, 10, 90, 1, 9, 3, 2};
    vecs[1] = '{4'b0000, -1, -1, 7, 63, 1, 6, 0, 1};
    vecs[2] = '{4'b1111, -1, -1, 11, 99, 1, 10, 4, 5};
    vecs[3] = '{4'b0001, -1, -1, 8, 72, 1, 7, 1, 7};
    vecs[4] = '{4'b1000, -1, -1, 8, 72, 1, 7, 1, 3};
    vecs[5] = '{4'b1011, 12, -1, 10, 94, 1, 9, 3, 2};
    vecs[6] = '{4'b1011, -1, 40, 10, 90, 1, 9, 3, 2};
    #2 rstb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 13'b0_1_0_0_1_00_00_0_0_0_0);
    rstb = 1;
    @(posedge clk); #1;
    en = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("start_with_en_low_busy", int'(busy), 0);
    @(posedge clk); #1;
    exp = 4'b1011;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #2;
    chk("third_run_cycle_sig", int'({mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock, busy}), 6'b110001);
    rstb = 0;
    #1;
    chk("reset_mid_run_outputs", outs(), 13'b0_1_0_0_1_00_00_0_0_0_0);
    @(negedge clk);
    rstb = 1;
    for (int i = 0; i < 7; i++) run(vecs[i], i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
